// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scan_unload.sv
// Scan unload: captures a flop bank's parallel Q outputs and streams them out LSB first
// over a valid/ready serial port. Define GF180MCU_SCAN_UNLOAD_PARITY_EN to append an even-parity beat.
module gf180mcu_fd_sc_mcu9t5v0__scan_unload #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CAP,
    input  logic [WIDTH-1:0] PI,
    output logic             SO,
    output logic             SO_VLD,
    input  logic             SO_RDY,
    output logic             BUSY,
    output logic             DONE,
    input  logic             VDD,
    input  logic             VSS
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             done_q;
    logic             ld, xfer, fin, vld, so_d;
`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
    logic             par_q;
`endif

    // Supply pins carry no function in the behavioural view.
    logic unused_pwr;
    assign unused_pwr = VDD ^ VSS;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt  = state;
        ld   = 1'b0;
        xfer = 1'b0;
        fin  = 1'b0;
        vld  = 1'b0;
        so_d = 1'b0;
        case (state)
            IDLE: begin
                if (CAP) begin
                    ld  = 1'b1;
                    nxt = SHIFT;
                end
            end
            SHIFT: begin
                vld  = 1'b1;
                so_d = sr[0];
                if (SO_RDY) begin
                    xfer = 1'b1;
                    if (cnt == LAST) begin
`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
                        nxt = PAR;
`else
                        nxt = IDLE;
                        fin = 1'b1;
`endif
                    end
                end
            end
`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
            PAR: begin
                vld  = 1'b1;
                so_d = par_q;
                if (SO_RDY) begin
                    nxt = IDLE;
                    fin = 1'b1;
                end
            end
`endif
            default: nxt = IDLE;
        endcase
    end

    // Datapath; the counter saturates at the final beat index instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr     <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            done_q <= fin;
            if (ld) begin
                sr    <= PI;
                cnt   <= '0;
`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
                par_q <= ^PI;
`endif
            end else if (xfer) begin
                sr <= {1'b0, sr[WIDTH-1:1]};
                if (cnt != LAST) cnt <= cnt + CW'(1);
            end
        end
    end

    assign SO     = so_d;
    assign SO_VLD = vld;
    assign BUSY   = vld;
    assign DONE   = done_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__scan_unload.sv
// Directed bench for the scan unload block: reset, streaming, stalls, mid-unload reset, back-to-back captures.
module tb_gf180mcu_fd_sc_mcu9t5v0__scan_unload;

    localparam int W = 16;
`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
    localparam int BEATS = W + 1;
`else
    localparam int BEATS = W;
`endif

    logic         CLK = 1'b0;
    logic         RST, CAP, SO_RDY;
    logic         VDD = 1'b1;
    logic         VSS = 1'b0;
    logic [W-1:0] PI;
    logic         SO, SO_VLD, BUSY, DONE;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu9t5v0__scan_unload #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .CAP(CAP), .PI(PI), .SO(SO), .SO_VLD(SO_VLD),
        .SO_RDY(SO_RDY), .BUSY(BUSY), .DONE(DONE), .VDD(VDD), .VSS(VSS)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // 16'hA5C3 LSB first, followed by its even parity (0).
    int seq[17] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,0};
    logic [15:0] w1, w2;
    int beat, cyc;

    initial begin
        RST = 1'b1; CAP = 1'b0; SO_RDY = 1'b0; PI = '0;
        #2;
        chk("rst_so", SO, 0);
        chk("rst_vld", SO_VLD, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        step; step;
        RST = 1'b0;

        // Ready while idle does nothing
        SO_RDY = 1'b1;
        step;
        chk("idle_rdy_vld", SO_VLD, 0);
        chk("idle_rdy_so", SO, 0);

        // Continuous-ready unload of A5C3; PI scrambled after capture
        PI = 16'hA5C3; CAP = 1'b1;
        step;
        CAP = 1'b0; PI = 16'h0000;
        for (int i = 0; i < BEATS; i++) begin
            chk($sformatf("cont_so%0d", i), SO, seq[i]);
            chk($sformatf("cont_vld%0d", i), SO_VLD, 1);
            chk($sformatf("cont_busy%0d", i), BUSY, 1);
            chk($sformatf("cont_done%0d", i), DONE, 0);
            step;
        end
        chk("cont_done", DONE, 1);
        chk("cont_done_vld", SO_VLD, 0);
        chk("cont_done_busy", BUSY, 0);
        step;
        chk("cont_done_pulse", DONE, 0);

        // Ready toggling every cycle: same bits, SO held during stalls
        PI = 16'hA5C3; CAP = 1'b1;
        step;
        CAP = 1'b0;
        beat = 0; cyc = 0;
        while (beat < BEATS && cyc < 64) begin
            SO_RDY = (cyc % 2 == 0);
            chk($sformatf("stall_so_c%0d", cyc), SO, seq[beat]);
            chk($sformatf("stall_vld_c%0d", cyc), SO_VLD, 1);
            if (SO_RDY) beat++;
            step;
            cyc++;
        end
        chk("stall_cycles", cyc, 2 * BEATS - 1);
        chk("stall_done", DONE, 1);
        SO_RDY = 1'b1;
        step;

        // Reset after 5 transfers aborts without DONE
        PI = 16'h1234; CAP = 1'b1;
        step;
        CAP = 1'b0;
        repeat (5) step;
        RST = 1'b1;
        #1;
        chk("abort_vld", SO_VLD, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_so", SO, 0);
        chk("abort_done", DONE, 0);
        step; step;
        chk("abort_done_held", DONE, 0);
        RST = 1'b0;
        step;
        chk("abort_wait_vld", SO_VLD, 0);
        chk("abort_wait_done", DONE, 0);

        // CAP on the first edge after reset release is honoured
        RST = 1'b1;
        #2;
        RST = 1'b0; CAP = 1'b1; PI = 16'hFFFF;
        step;
        CAP = 1'b0;
        chk("rel_cap_vld", SO_VLD, 1);
        for (int i = 0; i < W; i++) begin
            chk($sformatf("ones_so%0d", i), SO, 1);
            step;
        end
`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
        chk("ones_par", SO, 0);
        step;
`endif
        chk("ones_done", DONE, 1);

        // CAP held across two unloads; PI changes mid-unload
        w1 = 16'h00F0; w2 = 16'h3C5A;
        PI = w1; CAP = 1'b1;
        step;
        for (int i = 0; i < W; i++) begin
            if (i == 4)  PI = 16'hFFFF;
            if (i == 15) PI = w2;
            chk($sformatf("b2b1_so%0d", i), SO, w1[i]);
            chk($sformatf("b2b1_busy%0d", i), BUSY, 1);
            step;
        end
`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
        chk("b2b1_par", SO, 0);
        step;
`endif
        chk("b2b1_done", DONE, 1);
        chk("b2b1_done_vld", SO_VLD, 0);
        step;
        chk("b2b2_vld_rise", SO_VLD, 1);
        chk("b2b2_done_low", DONE, 0);
        PI = 16'h0000;
        for (int i = 0; i < W; i++) begin
            chk($sformatf("b2b2_so%0d", i), SO, w2[i]);
            step;
        end
`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
        chk("b2b2_par", SO, 0);
        step;
`endif
        chk("b2b2_done", DONE, 1);
        CAP = 1'b0;
        step;
        chk("b2b2_idle_vld", SO_VLD, 0);

`ifdef GF180MCU_SCAN_UNLOAD_PARITY_EN
        PI = 16'h0001; CAP = 1'b1;
        step;
        CAP = 1'b0;
        repeat (W) step;
        chk("par1_so", SO, 1);
        chk("par1_vld", SO_VLD, 1);
        step;
        chk("par1_done", DONE, 1);
        PI = 16'h0003; CAP = 1'b1;
        step;
        CAP = 1'b0;
        repeat (W) step;
        chk("par0_so", SO, 0);
        chk("par0_vld", SO_VLD, 1);
        step;
        chk("par0_done", DONE, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__scan_unload.md
GF180MCU_FD_SC_MCU9T5V0__SCAN_UNLOAD -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__scan_unload

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of captured flop bits; legal range 2..64.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port CAP, input, 1 bit: capture request, sampled only in IDLE.
REQ-005 The block SHALL have port PI, input, WIDTH bits: parallel Q outputs of the flop bank being read.
REQ-006 The block SHALL have port SO, output, 1 bit: serial data out, LSB first.
REQ-007 The block SHALL have port SO_VLD, output, 1 bit: SO holds a valid beat.
REQ-008 The block SHALL have port SO_RDY, input, 1 bit: sink accepts the beat; a beat transfers on a CLK edge with SO_VLD=1 and SO_RDY=1.
REQ-009 The block SHALL have port BUSY, output, 1 bit: an unload is in progress.
REQ-010 The block SHALL have port DONE, output, 1 bit: one-cycle pulse after the final beat transfers.
REQ-011 The block SHALL have ports VDD and VSS, input, 1 bit each, with no functional effect.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, and PAR (PAR present only per REQ-026).
REQ-013 In IDLE, SO_VLD=0, BUSY=0, SO=0.
REQ-014 CAP=1 at a CLK edge in IDLE SHALL load PI into the shift register, clear the beat counter, and enter SHIFT; SO_VLD=1 from the following cycle (one-cycle capture latency).
REQ-015 In SHIFT, SO SHALL equal shift-register bit 0, and SO_VLD=1 and BUSY=1.
REQ-016 Each transfer in SHIFT SHALL shift the register right by one (zero fill) and increment the counter; the counter is ceil(log2(WIDTH)) bits wide and never wraps.
REQ-017 SO SHALL remain stable while SO_VLD=1 and SO_RDY=0, and no stall length SHALL cause data loss.
REQ-018 A transfer with counter = WIDTH-1 SHALL end SHIFT: go to PAR if enabled, otherwise to IDLE with DONE=1 for the next cycle.
REQ-019 CAP SHALL be ignored outside IDLE, and PI changes after capture SHALL not affect the unloaded data.
REQ-020 DONE=1 and CAP=1 in the same cycle (the block is then in IDLE) SHALL start a new capture; back-to-back unloads therefore need zero idle beats beyond the DONE cycle.
REQ-021 SO_RDY while SO_VLD=0 SHALL have no effect.

Reset
REQ-022 RST=1 SHALL immediately force IDLE with SO=0, SO_VLD=0, BUSY=0, DONE=0, the shift register cleared, and the counter cleared, independent of CLK.
REQ-023 RST asserted mid-unload SHALL abort the unload without a DONE pulse; after release, the block SHALL wait for a new CAP.
REQ-024 Release of RST SHALL take effect on the first CLK edge after deassertion, and CAP sampled on that edge SHALL be honoured.

Configuration
REQ-025 Macro GF180MCU_SCAN_UNLOAD_PARITY_EN SHALL select the parity feature.
REQ-026 With the macro defined: the even parity (XOR of all PI bits) is registered at capture; the PAR state presents it on SO with SO_VLD=1 as beat WIDTH+1; its transfer returns the block to IDLE with DONE.
REQ-027 Without the macro: PAR and its parity flop do not exist, and an unload is exactly WIDTH beats.

Verification
REQ-028 WIDTH=16, SO_RDY=1 constantly, CAP pulse with PI=16'hA5C3 -> SO sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles, DONE exactly one cycle after the 16th beat, BUSY high for 16 cycles.
REQ-029 Same capture, SO_RDY toggling 1/0 every cycle -> identical bit sequence, SO stable during every stall cycle, 16 transfers over 31 cycles.
REQ-030 Parity build, PI=16'h0001 -> 17 beats, 17th beat=1; PI=16'h0003 -> 17th beat=0.
REQ-031 RST pulse after 5 transfers -> SO_VLD/BUSY drop asynchronously, no DONE; a new CAP with PI=16'hFFFF -> 16 ones.
REQ-032 CAP held high throughout two unloads with PI changing mid-unload -> each unload outputs the value present at its capture edge, and the second SO_VLD rises the cycle after DONE.
